// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and in-order fetch buffer feeding decode
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] Address,
   input  logic [31:0] Instruction,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   input  logic        OutReady,
   output logic        OutValid,
   output logic [31:0] OutInstruction,
   output logic [31:0] OutPC,
   output logic [31:0] OutPCPlus4
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   pc;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   buf_ins [DEPTH];
   logic [31:0]   buf_pc  [DEPTH];
   logic          pop;
   logic          fetch;

   assign Address  = pc;
   assign OutValid = (count != '0);
   assign pop      = OutValid & OutReady;
   // A slot freed by this cycle's pop can be refilled on the same edge.
   assign fetch    = ~Redirect & ((count < FULL) | pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc     <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (Redirect) begin
         pc     <= {RedirectPC[31:2], 2'b00};
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (fetch) begin
            pc     <= pc + 32'd4;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fetch, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_ins[i] <= '0;
            buf_pc[i]  <= '0;
         end
      end else if (fetch) begin
         buf_ins[wr_ptr] <= Instruction;
         buf_pc[wr_ptr]  <= pc;
      end
   end

   // Data outputs are forced to zero when nothing valid is at the head.
   assign OutInstruction = OutValid ? buf_ins[rd_ptr] : '0;
   assign OutPC          = OutValid ? buf_pc[rd_ptr] : '0;
   assign OutPCPlus4     = OutValid ? (buf_pc[rd_ptr] + 32'd4) : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk;
   logic        reset_n;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        OutReady;
   logic        OutValid;
   logic [31:0] OutInstruction;
   logic [31:0] OutPC;
   logic [31:0] OutPCPlus4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] m_pc;
   int          total;
   int          bad;

   instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .Address        (Address),
      .Instruction    (Instruction),
      .Redirect       (Redirect),
      .RedirectPC     (RedirectPC),
      .OutReady       (OutReady),
      .OutValid       (OutValid),
      .OutInstruction (OutInstruction),
      .OutPC          (OutPC),
      .OutPCPlus4     (OutPCPlus4)
   );

   // memory word at byte address a is a/4
   assign #1 Instruction = {2'b00, Address[31:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a buffer of capacity DEPTH filled in address order
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
         m_pc <= RESET_PC;
      end else if (Redirect) begin
         exp_q.delete();
         m_pc <= RedirectPC & 32'hFFFF_FFFC;
      end else if (exp_q.size() < DEPTH) begin
         exp_q.push_back('{pc: m_pc, ins: m_pc >> 2});
         m_pc <= m_pc + 32'd4;
      end
   end

   // Monitor: compares the presented head and retires it on a transfer
   always @(negedge clk) begin
      chk("address", Address, m_pc);
      chk("out_valid", 32'(OutValid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("out_pc", OutPC, exp_q[0].pc);
         chk("out_instruction", OutInstruction, exp_q[0].ins);
         chk("out_pc_plus4", OutPCPlus4, exp_q[0].pc + 32'd4);
         if (OutReady) void'(exp_q.pop_front());
      end else begin
         chk("idle_pc_zero", OutPC, 32'h0);
         chk("idle_ins_zero", OutInstruction, 32'h0);
         chk("idle_plus4_zero", OutPCPlus4, 32'h0);
      end
   end

   task automatic step(input logic rd, input logic redir, input logic [31:0] tgt);
      @(posedge clk);
      #2;
      OutReady   = rd;
      Redirect   = redir;
      RedirectPC = tgt;
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", 32'(OutValid), 32'h0);
      chk("async_reset_address", Address, RESET_PC);
      @(posedge clk);
      #2;
      Redirect = 1'b0;
      reset_n  = 1'b1;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset_n    = 1'b0;
      Redirect   = 1'b0;
      RedirectPC = 32'h0;
      OutReady   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_address", Address, RESET_PC);
      chk("reset_valid", 32'(OutValid), 32'h0);
      reset_n  = 1'b1;
      OutReady = 1'b1;

      // streaming, then a 6-cycle stall, then drain
      repeat (8) step(1'b1, 1'b0, 32'h0);
      repeat (6) step(1'b0, 1'b0, 32'h0);
      repeat (4) step(1'b1, 1'b0, 32'h0);

      // redirect with a full buffer
      repeat (3) step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0040);
      repeat (2) step(1'b0, 1'b0, 32'h0);
      repeat (3) step(1'b1, 1'b0, 32'h0);

      // unaligned target and PC wrap
      step(1'b1, 1'b1, 32'h0000_0043);
      repeat (3) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (4) step(1'b1, 1'b0, 32'h0);

      // asynchronous reset while full
      repeat (3) step(1'b0, 1'b0, 32'h0);
      reset_pulse();
      repeat (4) step(1'b1, 1'b0, 32'h0);

      // redirect with a simultaneous pop, then redirect held for 3 cycles
      step(1'b1, 1'b1, 32'h0000_0080);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h0000_0100);
      step(1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b1, 32'h0000_0302);
      repeat (5) step(1'b1, 1'b0, 32'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         logic [31:0] tgt;
         logic        rd;
         logic        redir;
         rd    = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else tgt = $urandom;
         if ($urandom_range(0, 99) == 0) reset_pulse();
         else step(rd, redir, tgt);
      end

      step(1'b1, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
